// File: rtl/junction_controller.sv
// ---------------------------------------------------------------------------
// junction_controller
//   Two-road junction sequencer (North-South / East-West) using the UK lamp
//   order red -> red+amber -> green -> amber -> red, with an all-red gap
//   between roads and an optional pedestrian walk phase. The walk phase is
//   inserted only after East-West amber, and only when a request is latched.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   1 = dwell counter runs; 0 = hold state and counter
//   ped_req   in   pedestrian button, any pulse length
//   ns_red/ns_amber/ns_green   out  North-South lamps
//   ew_red/ew_amber/ew_green   out  East-West lamps
//   walk      out  pedestrian walk lamp (both roads red)
//   ped_wait  out  request latched but not yet served
// ---------------------------------------------------------------------------
module junction_controller #(
    parameter int T_GREEN     = 8,
    parameter int T_AMBER     = 3,
    parameter int T_RED_AMBER = 2,
    parameter int T_ALL_RED   = 1,
    parameter int T_WALK      = 6,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ped_req,
    output logic ns_red,
    output logic ns_amber,
    output logic ns_green,
    output logic ew_red,
    output logic ew_amber,
    output logic ew_green,
    output logic walk,
    output logic ped_wait
);

    typedef enum logic [3:0] {
        ALL_RED_A, NS_RA, NS_G, NS_A, ALL_RED_B, EW_RA, EW_G, EW_A, PED_WALK
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ped_pending, ped_nxt;

    // Counter reload value (dwell - 1) for the state being entered.
    function automatic logic [CNT_W-1:0] dwell_m1(input state_t s);
        case (s)
            NS_RA, EW_RA:         dwell_m1 = CNT_W'(T_RED_AMBER - 1);
            NS_G, EW_G:           dwell_m1 = CNT_W'(T_GREEN - 1);
            NS_A, EW_A:           dwell_m1 = CNT_W'(T_AMBER - 1);
            PED_WALK:             dwell_m1 = CNT_W'(T_WALK - 1);
            default:              dwell_m1 = CNT_W'(T_ALL_RED - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ALL_RED_A;
            cnt         <= CNT_W'(T_ALL_RED - 1);
            ped_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ped_pending <= ped_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ped_nxt   = ped_pending | ped_req;
        if (en) begin
            if (cnt == '0) begin
                case (state)
                    ALL_RED_A: state_nxt = NS_RA;
                    NS_RA:     state_nxt = NS_G;
                    NS_G:      state_nxt = NS_A;
                    NS_A:      state_nxt = ALL_RED_B;
                    ALL_RED_B: state_nxt = EW_RA;
                    EW_RA:     state_nxt = EW_G;
                    EW_G:      state_nxt = EW_A;
                    EW_A:      state_nxt = ped_pending ? PED_WALK : ALL_RED_A;
                    default:   state_nxt = ALL_RED_A;
                endcase
                cnt_nxt = dwell_m1(state_nxt);
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
        // Entering the walk serves the request; a press on that same edge
        // is considered served too.
        if (state_nxt == PED_WALK && state != PED_WALK)
            ped_nxt = 1'b0;
    end

    // Moore lamp decode: one pattern per state, never green/amber on both.
    always_comb begin
        ns_red   = 1'b1;
        ns_amber = 1'b0;
        ns_green = 1'b0;
        ew_red   = 1'b1;
        ew_amber = 1'b0;
        ew_green = 1'b0;
        walk     = 1'b0;
        case (state)
            NS_RA:    ns_amber = 1'b1;
            NS_G:     begin ns_red = 1'b0; ns_green = 1'b1; end
            NS_A:     begin ns_red = 1'b0; ns_amber = 1'b1; end
            EW_RA:    ew_amber = 1'b1;
            EW_G:     begin ew_red = 1'b0; ew_green = 1'b1; end
            EW_A:     begin ew_red = 1'b0; ew_amber = 1'b1; end
            PED_WALK: walk = 1'b1;
            default:  ;
        endcase
    end

    assign ped_wait = ped_pending;

endmodule
